// File: rtl/eep_wr_queue.sv
// eep_wr_queue: small write-request FIFO feeding the EEPROM charge-pump controller.
// Issues one wrt_eep strobe per entry and uses wr_busy (chrg_pmp_en) to pace writes.
module eep_wr_queue #(
  parameter int DATA_W   = 12,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 3,
  parameter int START_TO = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic              wrt_eep,
  output logic [DATA_W-1:0] wrt_data,
  input  logic              wr_busy,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMR_W = $clog2(START_TO);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TO - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] wrt_data_q, wrt_data_d;
  logic              err_q, err_d;
  logic              push, pop, set_err;

  assign req_ready   = (count_q != FULL_CNT);
  assign push        = req_valid && req_ready;
  assign wrt_eep     = (state_q == ISSUE);
  assign wrt_data    = wrt_data_q;
  assign fifo_count  = count_q;
  assign err_timeout = err_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    wrt_data_d = wrt_data_q;
    err_d      = err_q;
    pop        = 1'b0;
    set_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          wrt_data_d = mem_q[rd_ptr_q];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        timer_d = timer_q + 1'b1;
        // A busy controller wins over an expiring timer in the same cycle.
        if (wr_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TMR_LAST) begin
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!wr_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (set_err)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      wrt_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      wrt_data_q <= wrt_data_d;
      err_q      <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_data;
  end

endmodule
